// File: rtl/ps2_pkg.sv
// ps2_pkg: shared frame definitions and parity helper for the PS/2 receiver
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

    localparam int PS2_DATA_W     = 8;
    localparam int PS2_FRAME_BITS = 11;

    function automatic logic odd_parity_ok(input logic [PS2_DATA_W-1:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: show-ahead FIFO with separate fill count; output forced to 0 when empty
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = PS2_DATA_W
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop & ~empty;
    // a full FIFO still accepts a push when the same cycle frees a slot
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: oversampling PS/2 frame decoder feeding a show-ahead scan-code FIFO
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                            clk,
    input  logic                            clrn,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    input  logic                            rdn,
    output logic [PS2_DATA_W-1:0]           data,
    output logic                            ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            overflow,
    output logic                            frame_err,
    input  logic                            err_clr
);

    localparam int WDW      = $clog2(TIMEOUT_CYC+1);
    localparam int LAST_BIT = PS2_FRAME_BITS - 4;

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev, fall, bit_in, pop, frame_ok, push, bad_frame, timeout;
    logic                   full, empty;
    ps2_state_t             state;
    logic [2:0]             bitcnt;
    logic [PS2_DATA_W-1:0]  shreg;
    logic                   par;
    logic [WDW-1:0]         wdog;

    assign fall      = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in    = data_sync[SYNC_STAGES-1];
    assign pop       = ~rdn;
    assign frame_ok  = bit_in & odd_parity_ok(shreg, par);
    assign push      = fall && state == STOP && frame_ok;
    assign bad_frame = fall && state == STOP && !frame_ok;
    // a fall in the expiry cycle counts as activity and wins over the abort
    assign timeout   = state != IDLE && !fall && wdog == WDW'(TIMEOUT_CYC - 1);
    assign ready     = ~empty;

    // synchronise the raw PS/2 lines; idle-high so reset cannot fake a falling edge
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    // frame FSM and watchdog, stepping on each synchronised ps2_clk fall
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            par    <= 1'b0;
            wdog   <= '0;
        end else if (timeout) begin
            state <= IDLE;
            wdog  <= '0;
        end else if (fall) begin
            wdog <= '0;
            case (state)
                IDLE: begin
                    if (!bit_in) begin
                        state  <= DATA;
                        bitcnt <= '0;
                    end
                end
                DATA: begin
                    shreg  <= {bit_in, shreg[PS2_DATA_W-1:1]};
                    bitcnt <= bitcnt + 1'b1;
                    if (bitcnt == 3'(LAST_BIT)) state <= PARITY;
                end
                PARITY: begin
                    par   <= bit_in;
                    state <= STOP;
                end
                STOP: state <= IDLE;
            endcase
        end else begin
            wdog <= state != IDLE ? wdog + 1'b1 : '0;
        end
    end

    // sticky error flags; a clear beats a same-cycle set
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= err_clr ? 1'b0 : overflow | (push & full & ~pop);
            frame_err <= err_clr ? 1'b0 : frame_err | bad_frame | timeout;
        end
    end

    ps2_fifo #(.DEPTH(FIFO_DEPTH), .W(PS2_DATA_W)) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (push),
        .wdata (shreg),
        .pop   (pop),
        .rdata (data),
        .empty (empty),
        .full  (full),
        .count (count)
    );

endmodule
